// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button debouncer.
// FSM encoding and the stability counter width.
package btn_pkg;

  typedef enum logic [1:0] {
    REL      = 2'd0,
    REL_WAIT = 2'd1,
    PRS      = 2'd2,
    PRS_WAIT = 2'd3
  } btn_state_e;

  function automatic int cnt_width(input int stable);
    return $clog2(stable + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, stability FSM/counter,
// registered level and press/release pulses.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic btn_reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  btn_state_e             r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_press;
  logic                   r_release;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  // Pulses are set on the same edge that changes the level,
  // so each lasts exactly one cycle.
  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      r_state   <= REL;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      unique case (r_state)
        REL: begin
          if (w_s) begin
            r_state <= REL_WAIT;
            r_cnt   <= ONE;
          end
        end
        REL_WAIT: begin
          if (!w_s) begin
            r_state <= REL;
            r_cnt   <= '0;
          end else if (r_cnt == LAST) begin
            r_state <= PRS;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        PRS: begin
          if (!w_s) begin
            r_state <= PRS_WAIT;
            r_cnt   <= ONE;
          end
        end
        PRS_WAIT: begin
          if (w_s) begin
            r_state <= PRS;
            r_cnt   <= '0;
          end else if (r_cnt == LAST) begin
            r_state   <= REL;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
      endcase
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel push-button conditioner: polarity fix-up
// followed by one independent debounce channel per button.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN         = 1,
  parameter int STABLE_CYCLES = 1000000,
  parameter int SYNC_STAGES   = 2,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic             clk,
  input  logic             btn_reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  logic [N_BTN-1:0] w_raw;

  assign w_raw = ACTIVE_LOW ? ~btn_in : btn_in;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .SYNC_STAGES  (SYNC_STAGES)
    ) u_ch (
      .clk      (clk),
      .btn_reset(btn_reset),
      .i_raw    (w_raw[g]),
      .o_level  (btn_level[g]),
      .o_press  (btn_press[g]),
      .o_release(btn_release[g])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: two instances, active-high
// and active-low, STABLE_CYCLES=4, SYNC_STAGES=2, N_BTN=2.
module tb_btn_debounce;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] in_hi = 2'b11;
  logic [1:0] in_lo = 2'b11;
  logic [1:0] lv_hi, pr_hi, rl_hi;
  logic [1:0] lv_lo, pr_lo, rl_lo;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  btn_debounce #(
    .N_BTN(2), .STABLE_CYCLES(4), .SYNC_STAGES(2), .ACTIVE_LOW(1'b0)
  ) u_hi (
    .clk(clk), .btn_reset(rst_n), .btn_in(in_hi),
    .btn_level(lv_hi), .btn_press(pr_hi), .btn_release(rl_hi)
  );

  btn_debounce #(
    .N_BTN(2), .STABLE_CYCLES(4), .SYNC_STAGES(2), .ACTIVE_LOW(1'b1)
  ) u_lo (
    .clk(clk), .btn_reset(rst_n), .btn_in(in_lo),
    .btn_level(lv_lo), .btn_press(pr_lo), .btn_release(rl_lo)
  );

  task automatic chk(input string tag, input logic [5:0] got,
                     input logic [5:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got lvl/prs/rel=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Step n cycles; level switches from l0 to l1 at cycle `at`,
  // where press/release equal pr/rl; elsewhere pulses are 0.
  task automatic watch(input string tag, input bit lo, input int n,
                       input int at, input logic [1:0] l0,
                       input logic [1:0] l1, input logic [1:0] pr,
                       input logic [1:0] rl);
    logic [5:0] got, exp;
    for (int i = 1; i <= n; i++) begin
      step();
      got = lo ? {lv_lo, pr_lo, rl_lo} : {lv_hi, pr_hi, rl_hi};
      exp = {(at != 0 && i >= at) ? l1 : l0,
             (i == at) ? pr : 2'b00,
             (i == at) ? rl : 2'b00};
      chk($sformatf("%s c%0d", tag, i), got, exp);
    end
  endtask

  initial begin
    // reset held with buttons pressed on the active-high unit
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rst_hi c%0d", i), {lv_hi, pr_hi, rl_hi}, 6'b0);
      chk($sformatf("rst_lo c%0d", i), {lv_lo, pr_lo, rl_lo}, 6'b0);
    end
    rst_n = 1'b1;
    watch("rst_rel", 1'b0, 8, 6, 2'b00, 2'b11, 2'b11, 2'b00);
    in_hi = 2'b00;
    watch("rel_both", 1'b0, 8, 6, 2'b11, 2'b00, 2'b00, 2'b11);

    // clean press on channel 0
    in_hi = 2'b01;
    watch("clean", 1'b0, 20, 6, 2'b00, 2'b01, 2'b01, 2'b00);

    // 3-cycle dropout while pressed must be ignored
    in_hi = 2'b00;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("glitch c%0d", i), {lv_hi, pr_hi, rl_hi},
          6'b01_00_00);
    end
    in_hi = 2'b01;
    watch("glitch_after", 1'b0, 10, 0, 2'b01, 2'b01, 2'b00, 2'b00);
    in_hi = 2'b00;
    watch("rel0", 1'b0, 8, 6, 2'b01, 2'b00, 2'b00, 2'b01);

    // bounce: toggle every 2 cycles for 12 cycles
    for (int t = 0; t < 12; t++) begin
      in_hi[0] = ((t / 2) % 2) == 0;
      step();
      chk($sformatf("bounce c%0d", t), {lv_hi, pr_hi, rl_hi}, 6'b0);
    end
    in_hi = 2'b01;
    watch("bounce_end", 1'b0, 10, 6, 2'b00, 2'b01, 2'b01, 2'b00);
    in_hi = 2'b00;
    watch("rel0b", 1'b0, 8, 6, 2'b01, 2'b00, 2'b00, 2'b01);

    // reset mid-count on channel 1
    in_hi = 2'b10;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("mid_pre c%0d", i), {lv_hi, pr_hi, rl_hi}, 6'b0);
    end
    rst_n = 1'b0;
    #1;
    chk("mid_async", {lv_hi, pr_hi, rl_hi}, 6'b0);
    for (int i = 1; i <= 2; i++) begin
      step();
      chk($sformatf("mid_rst c%0d", i), {lv_hi, pr_hi, rl_hi}, 6'b0);
    end
    rst_n = 1'b1;
    watch("mid_post", 1'b0, 10, 6, 2'b00, 2'b10, 2'b10, 2'b00);
    in_hi = 2'b00;
    watch("rel1", 1'b0, 8, 6, 2'b10, 2'b00, 2'b00, 2'b10);

    // active-low unit: stayed released so far
    chk("lo_idle", {lv_lo, pr_lo, rl_lo}, 6'b0);
    in_lo = 2'b10;
    watch("lo_prs0", 1'b1, 8, 6, 2'b00, 2'b01, 2'b01, 2'b00);
    in_lo = 2'b11;
    watch("lo_rel", 1'b1, 8, 6, 2'b01, 2'b00, 2'b00, 2'b01);
    in_lo = 2'b00;
    watch("lo_prs_both", 1'b1, 8, 6, 2'b00, 2'b11, 2'b11, 2'b00);
    in_lo = 2'b11;
    watch("lo_rel_both", 1'b1, 8, 6, 2'b11, 2'b00, 2'b00, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Front-end conditioner for the board's push-buttons, directly upstream of the LED counter top level. Synchronises raw asynchronous button inputs to `clk`, rejects contact bounce with a per-channel stability counter, and produces a clean level plus single-cycle press/release pulses. The counter/LED logic consumes these pulses, for example for step, pause or mode select.

## Interface
Parameters:
- `N_BTN`, 1, number of independent button channels.
- `STABLE_CYCLES`, 1000000, consecutive synchronised cycles an input must hold a new value before it is accepted (10 ms at 100 MHz); legal range ≥ 2.
- `SYNC_STAGES`, 2, synchroniser depth; legal range ≥ 2.
- `ACTIVE_LOW`, 0, 1 means a raw input reads pressed when low.

Ports:
- `clk`, in, 1, single system clock; all state is on its rising edge.
- `btn_reset`, in, 1, asynchronous, active-low reset; assertion clears all state immediately, deassertion is synchronous to `clk`.
- `btn_in`, in, `N_BTN`, raw button pins; asynchronous and bouncing.
- `btn_level`, out, `N_BTN`, debounced pressed state; 1 = pressed.
- `btn_press`, out, `N_BTN`, one-cycle pulse on each accepted press.
- `btn_release`, out, `N_BTN`, one-cycle pulse on each accepted release.

## Operation
- Polarity: when `ACTIVE_LOW`=1, each bit is inverted at the synchroniser input. Everything downstream uses logical pressed = 1.
- Synchroniser: a `SYNC_STAGES`-deep flop chain per channel; its last stage is the sample `s`.
- Per-channel FSM states:
  - `REL`: stable released; counter held at 0.
  - `REL_WAIT`: `s`=1 seen; counting up.
  - `PRS`: stable pressed; counter held at 0.
  - `PRS_WAIT`: `s`=0 seen; counting up.
- Transitions:
  - `REL`→`REL_WAIT` when `s`=1; counter loads 1.
  - In `REL_WAIT`: `s`=0 → `REL`, counter cleared. `s`=1 with counter = `STABLE_CYCLES`-1 → `PRS`. Otherwise the counter increments.
  - `PRS`/`PRS_WAIT` are symmetric with `s`=0, ending in `REL`.
- Counter width is `$clog2(STABLE_CYCLES+1)`. The counter never exceeds `STABLE_CYCLES`-1 and never wraps.
- `btn_level` is registered: 1 in `PRS`/`PRS_WAIT`, 0 otherwise.
- `btn_press` is 1 for exactly the cycle in which `btn_level` first reads 1. `btn_release` behaves the same way on the falling edge. The two pulses are never both 1 on the same channel.
- Channels are fully independent. Simultaneous events on different channels each produce their own pulses in the same cycle.
- Any bounce shorter than `STABLE_CYCLES` samples produces no output change.

## Timing
- Reset values:
  - `btn_level`=0, `btn_press`=0, `btn_release`=0.
  - FSM = `REL`, counter = 0.
  - Synchroniser flops hold the logical released value (0 after polarity inversion).
- Latency: a clean raw edge at cycle 0 makes the new `btn_level` value and its pulse visible at cycle `SYNC_STAGES`+`STABLE_CYCLES`.
- A press held continuously produces exactly one `btn_press` pulse. No auto-repeat.
- Reset asserted mid-count drops all outputs to 0 asynchronously. A pulse in flight is lost, not deferred.
- After reset release with the button already held: the press is accepted after the full latency and emits one `btn_press`.
- Minimum spacing between pulses of one channel is `STABLE_CYCLES` cycles.

## Structure
- Shared package `btn_pkg`:
  - FSM state encoding (`REL`, `REL_WAIT`, `PRS`, `PRS_WAIT`, 2 bits).
  - The counter-width helper.
- Sub-module `debounce_channel`: synchroniser, FSM, counter and pulse registers for one bit.
- `btn_debounce` instantiates `N_BTN` of `debounce_channel` in a generate loop and applies the `ACTIVE_LOW` inversion.

## Test plan
Bench uses `STABLE_CYCLES`=4, `SYNC_STAGES`=2, `N_BTN`=2.
- Reset: hold `btn_reset`=0 with `btn_in`=2'b11 → all outputs 0 throughout. Release reset → `btn_level`=2'b11 and one `btn_press`=2'b11 pulse exactly 6 cycles later.
- Clean press: `btn_in[0]` 0→1 at cycle 0 and held 20 cycles → `btn_level[0]` rises at cycle 6, `btn_press[0]`=1 only at cycle 6, `btn_release` stays 0.
- Bounce: `btn_in[0]` toggles every 2 cycles for 12 cycles, then held 1 → no output during the bounce; one `btn_press[0]` 6 cycles after the last edge.
- Glitch: with the channel pressed, `btn_in[0]`=0 for 3 cycles then back to 1 → `btn_level[0]` stays 1, no `btn_release[0]`.
- Mid-count reset: press `btn_in[1]`, assert `btn_reset` at cycle 4 for 2 cycles with the input still held → no pulse before reset, outputs 0 during reset, single `btn_press[1]` 6 cycles after reset deassertion.
- Polarity and independence: rebuild with `ACTIVE_LOW`=1. Drive `btn_in`=2'b10 → only channel 0 reports a press. Release both simultaneously → `btn_release`=2'b01 in the same cycle.
